// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state/select encodings, register-address width and source-match helper
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} ctrl_state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  // x0 is hardwired to zero, so it never creates a dependency
  function automatic logic reg_match(logic [REG_W-1:0] rs, logic used, logic [REG_W-1:0] rd);
    return used && (rs != '0) && (rs == rd);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/WB hazard inputs and sequencer controls; slave = hazard_ctrl, master = pipeline
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32);
  logic             id_vld;
  logic [REG_W-1:0] id_rs1, id_rs2;
  logic             id_rs1_used, id_rs2_used;
  logic [11:0]      id_csr;
  logic             id_csr_rd;
  logic [REG_W-1:0] EX_rd;
  logic             EX_rd_vld;
  logic [3:0]       EX_MEM_rden;
  logic             EX_jmp_vld;
  logic [11:0]      EX_csr;
  logic             EX_csr_vld;
  logic             EX_trap;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rd_vld;
  logic             ex_en, pc_hold, ifid_hold, idex_hold, ifid_flush;
  logic [1:0]       fwd_rs1_sel, fwd_rs2_sel;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport slave (
    input  id_vld, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_csr, id_csr_rd,
    input  EX_rd, EX_rd_vld, EX_MEM_rden, EX_jmp_vld, EX_csr, EX_csr_vld, EX_trap,
    input  wb_rd, wb_rd_vld,
    output ex_en, pc_hold, ifid_hold, idex_hold, ifid_flush,
    output fwd_rs1_sel, fwd_rs2_sel, ctrl_state, stall_cnt, flush_cnt
  );
  modport master (
    output id_vld, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_csr, id_csr_rd,
    output EX_rd, EX_rd_vld, EX_MEM_rden, EX_jmp_vld, EX_csr, EX_csr_vld, EX_trap,
    output wb_rd, wb_rd_vld,
    input  ex_en, pc_hold, ifid_hold, idex_hold, ifid_flush,
    input  fwd_rs1_sel, fwd_rs2_sel, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: per-operand dependency check; hz_o = must stall, sel_o = operand source (FORWARD_EN enables bypass)
module hazard_fwd_unit import hazard_ctrl_pkg::*; (
  input  logic [REG_W-1:0] rs_i,
  input  logic             used_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_rd_vld_i,
  input  logic             ex_ld_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_rd_vld_i,
  output logic             hz_o,
  output logic [1:0]       sel_o
);
  logic ex_hit, ld_hit, alu_hit, wb_hit;
  assign ex_hit  = ex_rd_vld_i & reg_match(rs_i, used_i, ex_rd_i);
  assign ld_hit  = ex_hit & ex_ld_i;
  assign alu_hit = ex_hit & ~ex_ld_i;
  assign wb_hit  = wb_rd_vld_i & reg_match(rs_i, used_i, wb_rd_i);
`ifdef FORWARD_EN
  // load data is not available at the EX output, so only a load dependency stalls
  assign hz_o  = ld_hit;
  assign sel_o = alu_hit ? FWD_EX : wb_hit ? FWD_WB : FWD_RF;
`else
  assign hz_o  = ld_hit | alu_hit | wb_hit;
  assign sel_o = FWD_RF;
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for EX enable, front-end hold/flush, forwarding selects and stall/flush counters
// Ports: clk, rst_n (sync active-low), hif (hazard_ctrl_if.slave). Optional macro FORWARD_EN enables operand bypass.
module hazard_ctrl import hazard_ctrl_pkg::*; #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hif
);
  ctrl_state_e      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hz1, hz2, csr_raw, redirect, hazard, stall_inc, flush_inc;
  logic [1:0]       sel1, sel2;
  hazard_fwd_unit u_rs1 (
    .rs_i(hif.id_rs1), .used_i(hif.id_rs1_used), .ex_rd_i(hif.EX_rd), .ex_rd_vld_i(hif.EX_rd_vld),
    .ex_ld_i(|hif.EX_MEM_rden), .wb_rd_i(hif.wb_rd), .wb_rd_vld_i(hif.wb_rd_vld), .hz_o(hz1), .sel_o(sel1)
  );
  hazard_fwd_unit u_rs2 (
    .rs_i(hif.id_rs2), .used_i(hif.id_rs2_used), .ex_rd_i(hif.EX_rd), .ex_rd_vld_i(hif.EX_rd_vld),
    .ex_ld_i(|hif.EX_MEM_rden), .wb_rd_i(hif.wb_rd), .wb_rd_vld_i(hif.wb_rd_vld), .hz_o(hz2), .sel_o(sel2)
  );
  assign redirect = hif.EX_jmp_vld | hif.EX_trap;
  assign csr_raw  = hif.id_csr_rd & hif.EX_csr_vld & (hif.EX_csr == hif.id_csr);
  assign hazard   = (hif.id_vld & (hz1 | hz2)) | csr_raw;
  // FLUSH holds cnt_q remaining bubbles after the redirect cycle itself; redirects are only honoured in RUN
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hif.ex_en      = 1'b0;
    hif.pc_hold    = 1'b0;
    hif.ifid_hold  = 1'b0;
    hif.idex_hold  = 1'b0;
    hif.ifid_flush = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (!rst_n) begin
      hif.pc_hold    = 1'b1;
      hif.ifid_flush = 1'b1;
      state_d        = RUN;
      cnt_d          = '0;
    end else if (state_q == FLUSH) begin
      hif.ifid_flush = 1'b1;
      flush_inc      = 1'b1;
      cnt_d          = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
      state_d        = (cnt_q <= 3'd1) ? RUN : FLUSH;
    end else if (state_q == RUN && redirect) begin
      hif.ifid_flush = 1'b1;
      flush_inc      = 1'b1;
      cnt_d          = 3'(FLUSH_CYCLES - 1);
      state_d        = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (hazard) begin
      hif.pc_hold    = 1'b1;
      hif.ifid_hold  = 1'b1;
      hif.idex_hold  = 1'b1;
      stall_inc      = 1'b1;
      state_d        = STALL;
    end else begin
      hif.ex_en      = hif.id_vld;
      state_d        = RUN;
    end
  end
  assign stall_cnt_d = (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_inc && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hif.fwd_rs1_sel = rst_n ? sel1 : FWD_RF;
  assign hif.fwd_rs2_sel = rst_n ? sel2 : FWD_RF;
  assign hif.ctrl_state  = state_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [4:0] ctl;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));
  assign ctl = {hif.ex_en, hif.pc_hold, hif.ifid_hold, hif.idex_hold, hif.ifid_flush};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    hif.id_vld = 0; hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_rs1_used = 0; hif.id_rs2_used = 0;
    hif.id_csr = 0; hif.id_csr_rd = 0; hif.EX_rd = 0; hif.EX_rd_vld = 0; hif.EX_MEM_rden = 0;
    hif.EX_jmp_vld = 0; hif.EX_csr = 0; hif.EX_csr_vld = 0; hif.EX_trap = 0; hif.wb_rd = 0; hif.wb_rd_vld = 0;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 0;
    hif.id_vld = 1; hif.id_rs1 = 5'd4; hif.id_rs1_used = 1; hif.EX_rd = 5'd4; hif.EX_rd_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b01001) begin errors++; $display("FAIL rst_ctl got %b want %b", ctl, 5'b01001); end
    checks++; if (hif.fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL rst_sel1 got %b want 00", hif.fwd_rs1_sel); end
    tick();
    rst_n = 1;
    hif.EX_rd_vld = 0;
    @(negedge clk);
    checks++; if (hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL rst_state got %b want 00", hif.ctrl_state); end
    checks++; if (hif.stall_cnt !== 0 || hif.flush_cnt !== 0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", hif.stall_cnt, hif.flush_cnt); end
    checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL rst_run_ctl got %b want %b", ctl, 5'b10000); end
  endtask
  task automatic test_load_use();
    do_reset();
    hif.id_vld = 1; hif.id_rs1 = 5'd5; hif.id_rs1_used = 1; hif.id_rs2 = 5'd7; hif.id_rs2_used = 1;
    hif.EX_rd = 5'd5; hif.EX_rd_vld = 1; hif.EX_MEM_rden = 4'b1111;
    @(negedge clk);
    checks++; if (ctl !== 5'b01110) begin errors++; $display("FAIL lu_stall_ctl got %b want %b", ctl, 5'b01110); end
    checks++; if (hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL lu_state0 got %b want 00", hif.ctrl_state); end
    tick();
    hif.EX_rd_vld = 0; hif.EX_MEM_rden = 0; hif.wb_rd = 5'd5; hif.wb_rd_vld = 1;
    @(negedge clk);
    checks++; if (hif.ctrl_state !== 2'b01) begin errors++; $display("FAIL lu_state1 got %b want 01", hif.ctrl_state); end
    checks++; if (hif.stall_cnt !== 1) begin errors++; $display("FAIL lu_cnt1 got %0d want 1", hif.stall_cnt); end
`ifdef FORWARD_EN
    checks++; if (ctl !== 5'b10000 || hif.fwd_rs1_sel !== 2'b10) begin errors++; $display("FAIL lu_fwd got ctl %b sel %b want 10000 10", ctl, hif.fwd_rs1_sel); end
    tick();
    hif.wb_rd_vld = 0;
    @(negedge clk);
    checks++; if (hif.stall_cnt !== 1 || hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL lu_end got cnt %0d st %b want 1 00", hif.stall_cnt, hif.ctrl_state); end
`else
    checks++; if (ctl !== 5'b01110 || hif.fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL lu_wb_stall got ctl %b sel %b want 01110 00", ctl, hif.fwd_rs1_sel); end
    tick();
    hif.wb_rd_vld = 0;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000 || hif.stall_cnt !== 2) begin errors++; $display("FAIL lu_end got ctl %b cnt %0d want 10000 2", ctl, hif.stall_cnt); end
`endif
  endtask
  task automatic test_back_to_back();
    do_reset();
    hif.id_vld = 1; hif.id_rs1 = 5'd9; hif.id_rs2 = 5'd3; hif.id_rs2_used = 1;
    hif.EX_rd = 5'd3; hif.EX_rd_vld = 1;
    @(negedge clk);
`ifdef FORWARD_EN
    checks++; if (ctl !== 5'b10000 || hif.fwd_rs2_sel !== 2'b01) begin errors++; $display("FAIL b2b_fwd got ctl %b sel %b want 10000 01", ctl, hif.fwd_rs2_sel); end
    checks++; if (hif.fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL b2b_rs1_unused got %b want 00", hif.fwd_rs1_sel); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (hif.stall_cnt !== 0 || hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL b2b_cnt got %0d st %b want 0 00", hif.stall_cnt, hif.ctrl_state); end
`else
    checks++; if (ctl !== 5'b01110) begin errors++; $display("FAIL b2b_s1 got %b want 01110", ctl); end
    tick();
    hif.EX_rd_vld = 0; hif.wb_rd = 5'd3; hif.wb_rd_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b01110 || hif.ctrl_state !== 2'b01) begin errors++; $display("FAIL b2b_s2 got ctl %b st %b want 01110 01", ctl, hif.ctrl_state); end
    tick();
    hif.wb_rd_vld = 0;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000 || hif.fwd_rs2_sel !== 2'b00) begin errors++; $display("FAIL b2b_go got ctl %b sel %b want 10000 00", ctl, hif.fwd_rs2_sel); end
    checks++; if (hif.stall_cnt !== 2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", hif.stall_cnt); end
    tick();
    @(negedge clk);
    checks++; if (hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL b2b_state got %b want 00", hif.ctrl_state); end
`endif
  endtask
  task automatic test_redirect();
    do_reset();
    hif.id_vld = 1; hif.id_rs1 = 5'd5; hif.id_rs1_used = 1;
    hif.EX_rd = 5'd5; hif.EX_rd_vld = 1; hif.EX_MEM_rden = 4'b0100; hif.EX_jmp_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b00001 || hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL jmp_c1 got ctl %b st %b want 00001 00", ctl, hif.ctrl_state); end
    tick();
    hif.EX_jmp_vld = 0;
    @(negedge clk);
    checks++; if (ctl !== 5'b00001 || hif.ctrl_state !== 2'b10) begin errors++; $display("FAIL jmp_c2 got ctl %b st %b want 00001 10", ctl, hif.ctrl_state); end
    tick();
    idle();
    hif.id_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000 || hif.ctrl_state !== 2'b00) begin errors++; $display("FAIL jmp_c3 got ctl %b st %b want 10000 00", ctl, hif.ctrl_state); end
    checks++; if (hif.flush_cnt !== 2 || hif.stall_cnt !== 0) begin errors++; $display("FAIL jmp_cnt got %0d/%0d want 2/0", hif.flush_cnt, hif.stall_cnt); end
    hif.EX_trap = 1;
    @(posedge clk);
    #4;
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL trap_ctl got %b want 00001", ctl); end
  endtask
  task automatic test_csr();
    do_reset();
    hif.id_vld = 1; hif.id_csr_rd = 1; hif.id_csr = 12'h300; hif.EX_csr = 12'h300; hif.EX_csr_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b01110) begin errors++; $display("FAIL csr_stall got %b want 01110", ctl); end
    tick();
    hif.EX_csr_vld = 0;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000 || hif.ctrl_state !== 2'b01 || hif.stall_cnt !== 1) begin errors++; $display("FAIL csr_resume got ctl %b st %b cnt %0d want 10000 01 1", ctl, hif.ctrl_state, hif.stall_cnt); end
    tick();
    hif.id_csr = 12'h305; hif.EX_csr_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL csr_nomatch got %b want 10000", ctl); end
  endtask
  task automatic test_x0();
    do_reset();
    hif.id_vld = 1; hif.id_rs1 = 5'd0; hif.id_rs1_used = 1; hif.id_rs2 = 5'd0; hif.id_rs2_used = 1;
    hif.EX_rd = 5'd0; hif.EX_rd_vld = 1; hif.wb_rd = 5'd0; hif.wb_rd_vld = 1;
    @(negedge clk);
    checks++; if (ctl !== 5'b10000 || hif.fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL x0_alu got ctl %b sel %b want 10000 00", ctl, hif.fwd_rs1_sel); end
    hif.EX_MEM_rden = 4'b0010;
    #1;
    checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL x0_load got %b want 10000", ctl); end
  endtask
  task automatic test_reset_in_flush();
    do_reset();
    hif.id_vld = 1; hif.EX_jmp_vld = 1;
    tick();
    hif.EX_jmp_vld = 0;
    rst_n = 0;
    @(negedge clk);
    checks++; if (ctl !== 5'b01001 || hif.ctrl_state !== 2'b10) begin errors++; $display("FAIL rf_ctl got ctl %b st %b want 01001 10", ctl, hif.ctrl_state); end
    tick();
    rst_n = 1;
    @(negedge clk);
    checks++; if (hif.ctrl_state !== 2'b00 || hif.flush_cnt !== 0 || hif.stall_cnt !== 0) begin errors++; $display("FAIL rf_after got st %b cnt %0d/%0d want 00 0/0", hif.ctrl_state, hif.flush_cnt, hif.stall_cnt); end
    checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL rf_en got %b want 10000", ctl); end
    hif.id_vld = 0;
    #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rf_noval got %b want 00000", ctl); end
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_redirect();
    test_csr();
    test_x0();
    test_reset_in_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
